// File: rtl/tmds_encoder_pipe_if.sv
// tmds_encoder_pipe_if
// Pixel-side and character-side signals of one TMDS encoder channel.
//   de    : data enable, 1 = video data, 0 = control period
//   din   : 8-bit pixel data (used while de=1)
//   ctrl  : 2-bit control code (used while de=0)
//   dout  : 10-bit TMDS character, bit 0 transmitted first
//   de_q  : de delayed to line up with dout
// master = pixel source / character sink, slave = encoder.
interface tmds_encoder_pipe_if;
    logic       de;
    logic [7:0] din;
    logic [1:0] ctrl;
    logic [9:0] dout;
    logic       de_q;

    modport master (output de, din, ctrl, input dout, de_q);
    modport slave  (input de, din, ctrl, output dout, de_q);
endinterface

// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe
// Two-stage 8b/10b TMDS encoder for one DVI/HDMI channel.
//   stage 1: transition minimisation (XOR/XNOR chain), registers q_m, its
//            ones count, de and ctrl
//   stage 2: DC balancing against a signed running disparity count, or
//            control-character selection during blanking
// Ports:
//   clk  : pixel clock
//   rst  : synchronous reset, active-high
//   bus  : tmds_encoder_pipe_if.slave (de, din, ctrl in; dout, de_q out)
// Latency is two clocks from input sample to dout/de_q, one character per clock.
module tmds_encoder_pipe #(
    parameter logic [9:0] CTRL0 = 10'b1101010100,
    parameter logic [9:0] CTRL1 = 10'b0010101011,
    parameter logic [9:0] CTRL2 = 10'b0101010100,
    parameter logic [9:0] CTRL3 = 10'b1010101011
) (
    input  logic                  clk,
    input  logic                  rst,
    tmds_encoder_pipe_if.slave    bus
);

    logic [3:0]        n1_din;
    logic              use_xnor;
    logic [8:0]        q_m;
    logic [3:0]        n1_qm;

    logic              de_s1;
    logic [1:0]        ctrl_s1;
    logic [8:0]        q_m_s1;
    logic [3:0]        n1q_s1;

    logic [9:0]        dout_r;
    logic              de_q_r;
    logic signed [4:0] cnt;

    logic [9:0]        dout_n;
    logic signed [4:0] cnt_n;
    logic signed [5:0] n1q_w;
    logic signed [5:0] n0q_w;
    logic signed [5:0] diff_w;
    logic signed [5:0] cnt_w;
    logic signed [5:0] sum_w;

    // Stage 1: choose the chain operator that minimises transitions.
    always_comb begin
        n1_din = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_din = n1_din + {3'b000, bus.din[i]};
        end
        use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && !bus.din[0]);
        q_m      = 9'd0;
        q_m[0]   = bus.din[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ bus.din[i]) : (q_m[i-1] ^ bus.din[i]);
        end
        q_m[8] = ~use_xnor;
        n1_qm  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_qm = n1_qm + {3'b000, q_m[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_s1   <= 1'b0;
            ctrl_s1 <= 2'b00;
            q_m_s1  <= 9'd0;
            n1q_s1  <= 4'd0;
        end else begin
            de_s1   <= bus.de;
            ctrl_s1 <= bus.ctrl;
            q_m_s1  <= q_m;
            n1q_s1  <= n1_qm;
        end
    end

    // Stage 2: disparity arithmetic is carried in 6 bits and truncated to the
    // 5-bit counter; the running value never leaves [-10, 10].
    always_comb begin
        dout_n = CTRL0;
        cnt_n  = 5'sd0;
        n1q_w  = signed'({2'b00, n1q_s1});
        n0q_w  = 6'sd8 - n1q_w;
        diff_w = n1q_w - n0q_w;
        cnt_w  = {cnt[4], cnt};
        sum_w  = cnt_w;
        if (!de_s1) begin
            case (ctrl_s1)
                2'b00:   dout_n = CTRL0;
                2'b01:   dout_n = CTRL1;
                2'b10:   dout_n = CTRL2;
                default: dout_n = CTRL3;
            endcase
            cnt_n = 5'sd0;
        end else begin
            if ((cnt == 5'sd0) || (n1q_s1 == 4'd4)) begin
                // Balanced word or fresh start: bit 9 only encodes whether to invert.
                dout_n = {~q_m_s1[8], q_m_s1[8], q_m_s1[8] ? q_m_s1[7:0] : ~q_m_s1[7:0]};
                sum_w  = q_m_s1[8] ? (cnt_w + diff_w) : (cnt_w - diff_w);
            end else if ((!cnt[4] && (n1q_s1 > 4'd4)) || (cnt[4] && (n1q_s1 < 4'd4))) begin
                // Word would push disparity further the same way: send it inverted.
                dout_n = {1'b1, q_m_s1[8], ~q_m_s1[7:0]};
                sum_w  = cnt_w + (q_m_s1[8] ? 6'sd2 : 6'sd0) - diff_w;
            end else begin
                dout_n = {1'b0, q_m_s1[8], q_m_s1[7:0]};
                sum_w  = cnt_w + diff_w - (q_m_s1[8] ? 6'sd0 : 6'sd2);
            end
            cnt_n = signed'(sum_w[4:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= CTRL0;
            de_q_r <= 1'b0;
            cnt    <= 5'sd0;
        end else begin
            dout_r <= dout_n;
            de_q_r <= de_s1;
            cnt    <= cnt_n;
        end
    end

    assign bus.dout = dout_r;
    assign bus.de_q = de_q_r;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb_tmds_encoder_pipe
// Directed vectors with hand-computed TMDS characters and disparity values,
// mid-stream reset, then a randomised stretch checked against a reference
// encoder and a loopback decoder.
module tb_tmds_encoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    tmds_encoder_pipe_if bus ();

    tmds_encoder_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [9:0] C0 = 10'b1101010100;
    localparam logic [9:0] C1 = 10'b0010101011;
    localparam logic [9:0] C2 = 10'b0101010100;
    localparam logic [9:0] C3 = 10'b1010101011;

    int checks   = 0;
    int failures = 0;

    // Character expected from the previously driven vector.
    bit         p_valid = 1'b0;
    string      p_tag;
    logic [9:0] p_dout;
    logic       p_de;
    logic [7:0] p_din;
    int         p_cnt;

    int         m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            assert (int'(dut.cnt) >= -10 && int'(dut.cnt) <= 10)
                else $error("cnt_bound violated cnt=%0d", dut.cnt);
        end
    end

    function automatic logic [9:0] ctrl_char(input logic [1:0] c);
        case (c)
            2'b00:   return C0;
            2'b01:   return C1;
            2'b10:   return C2;
            default: return C3;
        endcase
    endfunction

    // Reference encoder in integer arithmetic.
    task automatic ref_encode(input logic d, input logic [7:0] x, input logic [1:0] c,
                              output logic [9:0] o);
        int         n1;
        int         n1q;
        int         n0q;
        bit         xn;
        logic [8:0] qm;
        if (!d) begin
            o     = ctrl_char(c);
            m_cnt = 0;
        end else begin
            n1 = $countones(x);
            xn = (n1 > 4) || (n1 == 4 && x[0] == 1'b0);
            qm[0] = x[0];
            for (int i = 1; i < 8; i++)
                qm[i] = xn ? (qm[i-1] ~^ x[i]) : (qm[i-1] ^ x[i]);
            qm[8] = !xn;
            n1q = $countones(qm[7:0]);
            n0q = 8 - n1q;
            if (m_cnt == 0 || n1q == n0q) begin
                o     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
            end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
                o     = {1'b1, qm[8], ~qm[7:0]};
                m_cnt = m_cnt + 2 * int'(qm[8]) + (n0q - n1q);
            end else begin
                o     = {1'b0, qm[8], qm[7:0]};
                m_cnt = m_cnt + (n1q - n0q) - 2 * int'(!qm[8]);
            end
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] r;
        d    = w[9] ? ~w[7:0] : w[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++)
            r[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return r;
    endfunction

    // Drive one vector, then check the character owed by the previous one.
    task automatic cycle(input string tag, input logic d, input logic [7:0] x, input logic [1:0] c,
                         input logic [9:0] e_dout, input int e_cnt);
        @(negedge clk);
        bus.de   = d;
        bus.din  = x;
        bus.ctrl = c;
        @(posedge clk);
        #1;
        if (p_valid) begin
            check_eq({p_tag, "_dout"}, 32'(bus.dout), 32'(p_dout));
            check_eq({p_tag, "_de_q"}, 32'(bus.de_q), 32'(p_de));
            check_eq({p_tag, "_cnt"},  32'(int'(dut.cnt)), 32'(p_cnt));
            if (p_de)
                check_eq({p_tag, "_loopback"}, 32'(decode(bus.dout)), 32'(p_din));
        end
        p_valid = 1'b1;
        p_tag   = tag;
        p_dout  = e_dout;
        p_de    = d;
        p_din   = x;
        p_cnt   = e_cnt;
    endtask

    initial begin
        logic [9:0] e;
        logic       rd;
        logic [7:0] rx;
        logic [1:0] rc;

        bus.de = 1'b0; bus.din = 8'h00; bus.ctrl = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dout", 32'(bus.dout), 32'(C0));
        check_eq("rst_de_q", 32'(bus.de_q), 32'd0);
        check_eq("rst_cnt",  32'(int'(dut.cnt)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_dout", 32'(bus.dout), 32'(C0));
        check_eq("post_rst_de_q", 32'(bus.de_q), 32'd0);

        // Control characters; din is don't-care here.
        cycle("ctrl00", 1'b0, 8'hA5, 2'b00, C0, 0);
        cycle("ctrl01", 1'b0, 8'h5A, 2'b01, C1, 0);
        cycle("ctrl10", 1'b0, 8'hFF, 2'b10, C2, 0);
        cycle("ctrl11", 1'b0, 8'h00, 2'b11, C3, 0);

        // 0x00 twice from zero disparity; ctrl is don't-care during data.
        cycle("d00_a", 1'b1, 8'h00, 2'b11, 10'b0100000000, -8);
        cycle("d00_b", 1'b1, 8'h00, 2'b10, 10'b1111111111, 2);
        cycle("clr_a", 1'b0, 8'h00, 2'b00, C0, 0);

        // de toggling: each data character restarts from cnt=0.
        cycle("dff_a", 1'b1, 8'hFF, 2'b01, 10'b1000000000, -8);
        cycle("clr_b", 1'b0, 8'h33, 2'b00, C0, 0);
        cycle("dff_b", 1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);
        cycle("clr_c", 1'b0, 8'h00, 2'b00, C0, 0);

        // Single data pulse between control periods.
        cycle("d10",   1'b1, 8'h10, 2'b00, 10'b0111110000, 0);
        cycle("clr_d", 1'b0, 8'h00, 2'b00, C0, 0);

        // Run through all three balancing branches.
        cycle("seq_ff1", 1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);
        cycle("seq_ff2", 1'b1, 8'hFF, 2'b00, 10'b0011111111, -2);
        cycle("seq_10",  1'b1, 8'h10, 2'b00, 10'b0111110000, -2);
        cycle("seq_00",  1'b1, 8'h00, 2'b00, 10'b1111111111, 8);
        cycle("seq_ff3", 1'b1, 8'hFF, 2'b00, 10'b1000000000, 0);
        cycle("clr_e",   1'b0, 8'h00, 2'b00, C0, 0);
        cycle("clr_f",   1'b0, 8'h00, 2'b00, C0, 0);

        // Reset in the middle of data: in-flight characters are dropped.
        @(negedge clk);
        bus.de = 1'b1; bus.din = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.din = 8'hFF;
        @(posedge clk);
        #1;
        check_eq("midrst_dout", 32'(bus.dout), 32'(C0));
        check_eq("midrst_de_q", 32'(bus.de_q), 32'd0);
        check_eq("midrst_cnt",  32'(int'(dut.cnt)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        p_valid = 1'b0;
        bus.de = 1'b0;
        @(posedge clk);
        #1;
        cycle("after_rst_ff", 1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);
        check_eq("after_rst_first_dout", 32'(bus.dout), 32'(C0));
        check_eq("after_rst_first_de_q", 32'(bus.de_q), 32'd0);
        cycle("clr_g", 1'b0, 8'h00, 2'b00, C0, 0);

        // Randomised stretch against the reference encoder.
        m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rd = ($urandom_range(0, 3) != 0);
            rx = 8'($urandom);
            rc = 2'($urandom);
            ref_encode(rd, rx, rc, e);
            cycle("rand", rd, rx, rc, e, m_cnt);
        end
        cycle("flush", 1'b0, 8'h00, 2'b00, C0, 0);
        cycle("flush", 1'b0, 8'h00, 2'b00, C0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
